// File: rtl/smps_pkg.sv
// Shared constants and state encoding for the SMPS gate-drive blocks.
package smps_pkg;

  localparam int PWM_N_DEFAULT    = 10;
  localparam int PWM_DT_W_DEFAULT = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } pwm_state_e;

endpackage

// File: rtl/pwm_period_counter.sv
// Free-running period counter: counts 0..period-1 and wraps, parks at 0 for periods below 2.
module pwm_period_counter
  import smps_pkg::*;
#(
  parameter int N = PWM_N_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         clear,
  input  logic [N-1:0] period,
  output logic [N-1:0] cnt
);

  logic wrap;

  always_comb begin
    wrap = (period < N'(2)) || (cnt >= (period - N'(1)));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= wrap ? '0 : cnt + N'(1);
    end
  end

endmodule

// File: rtl/pwm_deadtime_gen.sv
// Complementary PWM gate-drive generator with dead-time insertion and latched fault shutdown.
module pwm_deadtime_gen
  import smps_pkg::*;
#(
  parameter int N    = PWM_N_DEFAULT,
  parameter int DT_W = PWM_DT_W_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_enable,
  input  logic [N-1:0]    i_period,
  input  logic [N-1:0]    i_duty,
  input  logic [DT_W-1:0] i_deadtime,
  input  logic            i_shutdown,
  input  logic            i_fault_clr,
  output logic            o_hs,
  output logic            o_ls,
  output logic            o_cycle_start,
  output logic            o_fault
);

  localparam int CW = N + 1;

  pwm_state_e      state, state_next;
  logic [N-1:0]    cnt;
  logic [N-1:0]    p_s, d_s;
  logic [DT_W-1:0] t_s;
  logic            run_stay, load_shadow, active;
  logic            hs_next, ls_next, start_next;
  logic [CW-1:0]   cnt_x, d_eff, t_x, ls_begin;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Shutdown outranks everything; a fault only clears once shutdown has dropped.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_shutdown) state_next = FAULT;
               else if (i_enable) state_next = RUN;
      RUN:     if (i_shutdown) state_next = FAULT;
               else if (!i_enable) state_next = IDLE;
      FAULT:   if (!i_shutdown && i_fault_clr) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  pwm_period_counter #(.N(N)) u_counter (
    .clk    (clk),
    .reset  (reset),
    .enable (run_stay),
    .clear  (!run_stay),
    .period (p_s),
    .cnt    (cnt)
  );

  // Window compares run one bit wider so duty plus dead-time cannot wrap; duty is clamped to the period.
  always_comb begin
    run_stay    = (state == RUN) && (state_next == RUN);
    load_shadow = ((state == IDLE) && (state_next == RUN)) ||
                  ((state == RUN) && (cnt == '0));
    cnt_x       = CW'(cnt);
    t_x         = CW'(t_s);
    d_eff       = (d_s > p_s) ? CW'(p_s) : CW'(d_s);
    ls_begin    = d_eff + t_x;
    active      = run_stay && (p_s >= N'(2));
    hs_next     = active && (t_x <= cnt_x) && (cnt_x < d_eff);
    ls_next     = active && (ls_begin <= cnt_x) && (cnt_x < CW'(p_s));
    start_next  = active && (cnt == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_s           <= '0;
      d_s           <= '0;
      t_s           <= '0;
      o_hs          <= 1'b0;
      o_ls          <= 1'b0;
      o_cycle_start <= 1'b0;
      o_fault       <= 1'b0;
    end else begin
      if (load_shadow) begin
        p_s <= i_period;
        d_s <= i_duty;
        t_s <= i_deadtime;
      end
      o_hs          <= hs_next;
      o_ls          <= ls_next;
      o_cycle_start <= start_next;
      o_fault       <= (state_next == FAULT);
    end
  end

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Directed and random stimulus for pwm_deadtime_gen with hand-derived expected waveforms.
module tb_pwm_deadtime_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_enable;
  logic [9:0] i_period;
  logic [9:0] i_duty;
  logic [5:0] i_deadtime;
  logic       i_shutdown;
  logic       i_fault_clr;
  logic       o_hs, o_ls, o_cycle_start, o_fault;

  int checks   = 0;
  int failures = 0;

  pwm_deadtime_gen #(.N(10), .DT_W(6)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_enable      (i_enable),
    .i_period      (i_period),
    .i_duty        (i_duty),
    .i_deadtime    (i_deadtime),
    .i_shutdown    (i_shutdown),
    .i_fault_clr   (i_fault_clr),
    .o_hs          (o_hs),
    .o_ls          (o_ls),
    .o_cycle_start (o_cycle_start),
    .o_fault       (o_fault)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge and outputs are sampled there too.
  task automatic go_idle();
    @(negedge clk);
    i_enable    = 1'b0;
    i_shutdown  = 1'b0;
    i_fault_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset       = 1'b0;
    i_enable    = 1'b0;
    i_period    = '0;
    i_duty      = '0;
    i_deadtime  = '0;
    i_shutdown  = 1'b0;
    i_fault_clr = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (o_hs !== 1'b0) begin failures++; $display("[TB] FAIL reset_hs got=%b exp=0", o_hs); end
    checks++; if (o_ls !== 1'b0) begin failures++; $display("[TB] FAIL reset_ls got=%b exp=0", o_ls); end
    checks++; if (o_cycle_start !== 1'b0) begin failures++; $display("[TB] FAIL reset_cs got=%b exp=0", o_cycle_start); end
    checks++; if (o_fault !== 1'b0) begin failures++; $display("[TB] FAIL reset_fault got=%b exp=0", o_fault); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if ({o_hs, o_ls, o_fault} !== 3'b000) begin failures++; $display("[TB] FAIL idle_outputs got=%b exp=000", {o_hs, o_ls, o_fault}); end
  endtask

  // P=100 D=40 T=5: hs on counts 5..39, ls on counts 45..99, outputs lag the count by one cycle.
  task automatic test_basic();
    int c;
    logic [2:0] exp_v;
    i_period = 10'd100; i_duty = 10'd40; i_deadtime = 6'd5; i_enable = 1'b1;
    for (int k = 0; k <= 230; k++) begin
      @(negedge clk);
      if (k == 0) exp_v = 3'b000;
      else begin
        c = (k - 1) % 100;
        exp_v = {(c >= 5 && c < 40), (c >= 45 && c < 100), (c == 0)};
      end
      checks++;
      if ({o_hs, o_ls, o_cycle_start} !== exp_v) begin
        failures++;
        $display("[TB] FAIL basic k=%0d hs/ls/cs got=%b exp=%b", k, {o_hs, o_ls, o_cycle_start}, exp_v);
      end
    end
    i_enable = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_hs, o_ls, o_cycle_start} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL disable hs/ls/cs got=%b exp=000", {o_hs, o_ls, o_cycle_start});
    end
    go_idle();
  endtask

  task automatic test_clamp();
    int c;
    logic [2:0] exp_v;
    i_period = 10'd100; i_duty = 10'd120; i_deadtime = 6'd5; i_enable = 1'b1;
    for (int k = 0; k <= 150; k++) begin
      @(negedge clk);
      if (k == 0) exp_v = 3'b000;
      else begin
        c = (k - 1) % 100;
        exp_v = {(c >= 5), 1'b0, (c == 0)};
      end
      checks++;
      if ({o_hs, o_ls, o_cycle_start} !== exp_v) begin
        failures++;
        $display("[TB] FAIL clamp k=%0d hs/ls/cs got=%b exp=%b", k, {o_hs, o_ls, o_cycle_start}, exp_v);
      end
    end
    go_idle();
  endtask

  // Duty moves 40->60 while the count is 50; only the following period sees it.
  task automatic test_duty_change();
    int c, d;
    logic [2:0] exp_v;
    i_period = 10'd100; i_duty = 10'd40; i_deadtime = 6'd5; i_enable = 1'b1;
    for (int k = 0; k <= 201; k++) begin
      @(negedge clk);
      if (k == 0) exp_v = 3'b000;
      else begin
        c = (k - 1) % 100;
        d = (k - 1 < 100) ? 40 : 60;
        exp_v = {(c >= 5 && c < d), (c >= d + 5 && c < 100), (c == 0)};
      end
      checks++;
      if ({o_hs, o_ls, o_cycle_start} !== exp_v) begin
        failures++;
        $display("[TB] FAIL duty_change k=%0d hs/ls/cs got=%b exp=%b", k, {o_hs, o_ls, o_cycle_start}, exp_v);
      end
      if (k == 50) i_duty = 10'd60;
    end
    go_idle();
  endtask

  task automatic test_min_period();
    int c;
    logic [2:0] exp_v;
    i_period = 10'd1; i_duty = 10'd1; i_deadtime = 6'd0; i_enable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 10) i_period = 10'd0;
      checks++;
      if ({o_hs, o_ls, o_cycle_start} !== 3'b000) begin
        failures++;
        $display("[TB] FAIL min_period k=%0d hs/ls/cs got=%b exp=000", k, {o_hs, o_ls, o_cycle_start});
      end
    end
    i_period = 10'd10; i_duty = 10'd4; i_deadtime = 6'd1;
    for (int k = 0; k <= 25; k++) begin
      @(negedge clk);
      if (k == 0) exp_v = 3'b000;
      else begin
        c = (k - 1) % 10;
        exp_v = {(c >= 1 && c < 4), (c >= 5 && c < 10), (c == 0)};
      end
      checks++;
      if ({o_hs, o_ls, o_cycle_start} !== exp_v) begin
        failures++;
        $display("[TB] FAIL short_period k=%0d hs/ls/cs got=%b exp=%b", k, {o_hs, o_ls, o_cycle_start}, exp_v);
      end
    end
    go_idle();
  endtask

  task automatic test_shutdown();
    int c;
    logic [2:0] exp_v;
    i_period = 10'd100; i_duty = 10'd40; i_deadtime = 6'd5; i_enable = 1'b1;
    for (int k = 0; k <= 20; k++) @(negedge clk);
    checks++; if (o_hs !== 1'b1) begin failures++; $display("[TB] FAIL pre_shutdown_hs got=%b exp=1", o_hs); end
    i_shutdown = 1'b1;
    @(negedge clk);
    checks++;
    if ({o_hs, o_ls, o_fault} !== 3'b001) begin
      failures++;
      $display("[TB] FAIL shutdown hs/ls/fault got=%b exp=001", {o_hs, o_ls, o_fault});
    end
    i_fault_clr = 1'b1;
    @(negedge clk);
    i_fault_clr = 1'b0;
    @(negedge clk);
    checks++; if (o_fault !== 1'b1) begin failures++; $display("[TB] FAIL clr_ignored fault got=%b exp=1", o_fault); end
    i_shutdown = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({o_hs, o_ls, o_fault} !== 3'b001) begin
      failures++;
      $display("[TB] FAIL fault_latched hs/ls/fault got=%b exp=001", {o_hs, o_ls, o_fault});
    end
    i_fault_clr = 1'b1;
    @(negedge clk);
    i_fault_clr = 1'b0;
    checks++;
    if ({o_hs, o_ls, o_fault} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL fault_cleared hs/ls/fault got=%b exp=000", {o_hs, o_ls, o_fault});
    end
    for (int k = 0; k <= 50; k++) begin
      @(negedge clk);
      if (k == 0) exp_v = 3'b000;
      else begin
        c = (k - 1) % 100;
        exp_v = {(c >= 5 && c < 40), (c >= 45 && c < 100), (c == 0)};
      end
      checks++;
      if ({o_hs, o_ls, o_cycle_start} !== exp_v) begin
        failures++;
        $display("[TB] FAIL restart k=%0d hs/ls/cs got=%b exp=%b", k, {o_hs, o_ls, o_cycle_start}, exp_v);
      end
    end
    go_idle();
  endtask

  task automatic test_reset_mid_run();
    int c;
    logic [2:0] exp_v;
    i_period = 10'd100; i_duty = 10'd40; i_deadtime = 6'd5; i_enable = 1'b1;
    for (int k = 0; k <= 70; k++) @(negedge clk);
    checks++; if (o_ls !== 1'b1) begin failures++; $display("[TB] FAIL pre_reset_ls got=%b exp=1", o_ls); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({o_hs, o_ls, o_cycle_start, o_fault} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL async_reset outputs got=%b exp=0000", {o_hs, o_ls, o_cycle_start, o_fault});
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k <= 50; k++) begin
      @(negedge clk);
      if (k == 0) exp_v = 3'b000;
      else begin
        c = (k - 1) % 100;
        exp_v = {(c >= 5 && c < 40), (c >= 45 && c < 100), (c == 0)};
      end
      checks++;
      if ({o_hs, o_ls, o_cycle_start} !== exp_v) begin
        failures++;
        $display("[TB] FAIL post_reset k=%0d hs/ls/cs got=%b exp=%b", k, {o_hs, o_ls, o_cycle_start}, exp_v);
      end
    end
    go_idle();
  endtask

  task automatic test_random();
    int overlaps = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (o_hs && o_ls) overlaps++;
      if ($urandom_range(31) == 0) i_period = 10'($urandom_range(40));
      if ($urandom_range(31) == 0) i_duty = 10'($urandom_range(45));
      if ($urandom_range(31) == 0) i_deadtime = 6'($urandom_range(7));
      i_enable    = ($urandom_range(15) != 0);
      i_shutdown  = ($urandom_range(99) == 0);
      i_fault_clr = ($urandom_range(7) == 0);
    end
    checks++;
    if (overlaps !== 0) begin
      failures++;
      $display("[TB] FAIL random_overlap cycles got=%0d exp=0", overlaps);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_duty_change();
    test_min_period();
    test_shutdown();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
